// File: rtl/pbi_dma_engine.sv
// pbi_dma_engine: multi-channel cycle-stealing DMA controller for a Phi2 bus.
// The controller runs on CLK1, which is 16x Phi2. A Phi2 cycle boundary is
// the CLK1 edge where Phi2 is seen 1 and then 0. All transfer state moves only
// at boundaries. Each boundary that finds Halt=0 and a busy channel grants the
// following Phi2 cycle to one channel, chosen round-robin.
//
// Ports:
//   CLK1      clock, 16x Phi2; all logic on posedge
//   Reset     synchronous, active-low reset
//   Phi2      system Phi2, sampled on CLK1
//   Halt      bus /HALT; 0 grants a DMA cycle
//   RegWr     one-CLK1 register write strobe
//   RegAddr   {channel, offset[2:0]}
//   RegWData  write data
//   RegRData  combinational read data
//   DmaReqOut bus request (any channel busy)
//   DmaCycle  current Phi2 cycle is a DMA cycle
//   DmaAddr   address of the current DMA cycle
//   DmaRead   1 = device-to-RAM, 0 = RAM-to-device
//   DmaDummy  current cycle is an alignment pad
//   DmaChan   channel owning the current cycle
//   Irq       level interrupt, OR of Done & IrqEn
//
// Register map per channel: 0 AddrLo, 1 AddrHi, 2 CountLo, 3 CountHi,
// 4 Control {Start, Abort, -, -, -, IrqEn, Pad, Dir}, 5 Status {Aborted, Done, Busy}.
module pbi_dma_engine #(
    parameter int NCH    = 2,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 16,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int CA_W  = 3 + $clog2(NCH)
) (
    input  logic              CLK1,
    input  logic              Reset,
    input  logic              Phi2,
    input  logic              Halt,
    input  logic              RegWr,
    input  logic [CA_W-1:0]   RegAddr,
    input  logic [7:0]        RegWData,
    output logic [7:0]        RegRData,
    output logic              DmaReqOut,
    output logic              DmaCycle,
    output logic [ADDR_W-1:0] DmaAddr,
    output logic              DmaRead,
    output logic              DmaDummy,
    output logic [CH_W-1:0]   DmaChan,
    output logic              Irq
);
    localparam int AV_W = (ADDR_W > 16) ? ADDR_W : 16;

    logic                r_phi2_d;
    logic [ADDR_W-1:0]   r_addr [NCH];
    logic [CNT_W-1:0]    r_count [NCH];
    logic [NCH-1:0]      r_dir, r_pad, r_irqen, r_busy, r_done, r_aborted;
    logic [NCH-1:0]      r_padpend, r_abort_req;
    logic                r_cyc, r_cyc_dummy, r_cyc_dir;
    logic [CH_W-1:0]     r_cyc_ch, r_rr_next;
    logic [ADDR_W-1:0]   r_cyc_addr;

    logic                w_bnd;
    logic [CH_W-1:0]     w_reg_ch;
    logic                w_reg_ok;
    logic [2:0]          w_off;
    logic [NCH-1:0]      w_sel, w_dat, w_fin, w_abt, w_elig, w_start, w_cnt_zero;
    logic [ADDR_W-1:0]   w_addr_nx [NCH];
    logic [CNT_W-1:0]    w_cnt_nx [NCH];
    logic                w_gnt_vld, w_gnt_dummy;
    logic [CH_W-1:0]     w_gnt_ch;

    assign w_bnd = r_phi2_d & ~Phi2;
    assign w_off = RegAddr[2:0];

    generate
        if (NCH > 1) begin : g_multi
            assign w_reg_ch = RegAddr[CA_W-1:3];
        end else begin : g_single
            assign w_reg_ch = '0;
        end
        // Non-power-of-two channel counts leave unused channel addresses.
        if ((1 << $clog2(NCH)) == NCH) begin : g_full
            assign w_reg_ok = 1'b1;
        end else begin : g_part
            assign w_reg_ok = (int'(w_reg_ch) < NCH);
        end
    endgenerate

    // Per-channel next state: completion of the granted cycle, pending aborts,
    // and register writes (which only land while the channel is idle).
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            logic [AV_W-1:0] v_a;
            logic [15:0]     v_c;
            w_sel[c]      = RegWr && w_reg_ok && (int'(w_reg_ch) == c);
            w_dat[c]      = w_bnd && r_cyc && (int'(r_cyc_ch) == c) && !r_cyc_dummy;
            w_fin[c]      = w_bnd && r_cyc && (int'(r_cyc_ch) == c)
                            && (r_cyc_dummy || (r_count[c] == CNT_W'(1) && !r_padpend[c]));
            // A cycle finishing at this boundary wins over the abort.
            w_abt[c]      = w_bnd && r_abort_req[c] && r_busy[c] && !w_fin[c];
            w_elig[c]     = r_busy[c] && !w_fin[c] && !w_abt[c];
            w_start[c]    = w_sel[c] && (w_off == 3'd4) && RegWData[7] && !r_busy[c];
            w_cnt_zero[c] = (r_count[c] == '0);
            v_a = AV_W'(r_addr[c]);
            v_c = 16'(r_count[c]);
            if (w_sel[c] && !r_busy[c]) begin
                case (w_off)
                    3'd0:    v_a[7:0]  = RegWData;
                    3'd1:    v_a[15:8] = RegWData;
                    3'd2:    v_c[7:0]  = RegWData;
                    3'd3:    v_c[15:8] = RegWData;
                    default: ;
                endcase
            end
            w_addr_nx[c] = w_dat[c] ? r_addr[c] + ADDR_W'(1) : ADDR_W'(v_a);
            w_cnt_nx[c]  = w_dat[c] ? r_count[c] - CNT_W'(1) : CNT_W'(v_c);
        end
    end

    // Round-robin: the first eligible channel at or after r_rr_next wins.
    always_comb begin
        int idx;
        idx       = 0;
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = (int'(r_rr_next) + i) % NCH;
            if (w_elig[idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_ch  = CH_W'(idx);
            end
        end
    end

    // A busy channel with zero count only exists while its pad cycle is owed.
    assign w_gnt_dummy = (w_cnt_nx[w_gnt_ch] == '0);

    always_ff @(posedge CLK1) begin
        if (!Reset) begin
            r_phi2_d    <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                r_addr[c]  <= '0;
                r_count[c] <= '0;
            end
            r_dir       <= '0;
            r_pad       <= '0;
            r_irqen     <= '0;
            r_busy      <= '0;
            r_done      <= '0;
            r_aborted   <= '0;
            r_padpend   <= '0;
            r_abort_req <= '0;
            r_cyc       <= 1'b0;
            r_cyc_dummy <= 1'b0;
            r_cyc_dir   <= 1'b0;
            r_cyc_ch    <= '0;
            r_cyc_addr  <= '0;
            r_rr_next   <= '0;
        end else begin
            r_phi2_d <= Phi2;
            for (int c = 0; c < NCH; c++) begin
                r_addr[c]  <= w_addr_nx[c];
                r_count[c] <= w_cnt_nx[c];
                if (w_sel[c] && w_off == 3'd4) begin
                    r_irqen[c] <= RegWData[2];
                    if (!r_busy[c]) begin
                        r_dir[c] <= RegWData[0];
                        r_pad[c] <= RegWData[1];
                    end
                end
                if (w_start[c] && !w_cnt_zero[c]) begin
                    r_busy[c]    <= 1'b1;
                    r_padpend[c] <= RegWData[1] & r_count[c][0];
                end else if (w_fin[c] || w_abt[c]) begin
                    r_busy[c]    <= 1'b0;
                    r_padpend[c] <= 1'b0;
                end
                // Set beats write-1-to-clear in the same CLK1.
                r_done[c]    <= w_fin[c] || (w_start[c] && w_cnt_zero[c])
                                || (r_done[c] && !(w_sel[c] && w_off == 3'd5 && RegWData[1]));
                r_aborted[c] <= w_abt[c]
                                || (r_aborted[c] && !(w_sel[c] && w_off == 3'd5 && RegWData[2]));
                r_abort_req[c] <= (w_fin[c] || w_abt[c]) ? 1'b0 :
                                  (r_abort_req[c] || (w_sel[c] && w_off == 3'd4
                                                      && RegWData[6] && r_busy[c]));
            end
            if (w_bnd) begin
                if (w_gnt_vld && !Halt) begin
                    r_cyc       <= 1'b1;
                    r_cyc_ch    <= w_gnt_ch;
                    r_cyc_addr  <= w_addr_nx[w_gnt_ch];
                    r_cyc_dir   <= r_dir[w_gnt_ch];
                    r_cyc_dummy <= w_gnt_dummy;
                    r_rr_next   <= CH_W'((int'(w_gnt_ch) + 1) % NCH);
                end else begin
                    r_cyc       <= 1'b0;
                    r_cyc_dummy <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        logic [AV_W-1:0] v_a;
        logic [15:0]     v_c;
        RegRData = '0;
        v_a      = '0;
        v_c      = '0;
        if (w_reg_ok) begin
            v_a = AV_W'(r_addr[w_reg_ch]);
            v_c = 16'(r_count[w_reg_ch]);
            case (w_off)
                3'd0:    RegRData = v_a[7:0];
                3'd1:    RegRData = v_a[15:8];
                3'd2:    RegRData = v_c[7:0];
                3'd3:    RegRData = v_c[15:8];
                3'd4:    RegRData = {5'b0, r_irqen[w_reg_ch], r_pad[w_reg_ch], r_dir[w_reg_ch]};
                3'd5:    RegRData = {5'b0, r_aborted[w_reg_ch], r_done[w_reg_ch], r_busy[w_reg_ch]};
                default: RegRData = '0;
            endcase
        end
    end

    assign DmaReqOut = |r_busy;
    assign Irq       = |(r_done & r_irqen);
    assign DmaCycle  = r_cyc;
    assign DmaAddr   = r_cyc_addr;
    assign DmaRead   = r_cyc_dir;
    assign DmaDummy  = r_cyc_dummy;
    assign DmaChan   = r_cyc_ch;

endmodule

// File: doc/pbi_dma_engine.md
PBI_DMA_ENGINE -- requirements
Module: pbi_dma_engine

Interface
REQ-001 SHALL provide parameter NCH, default 2, meaning the number of DMA channels (1..4).
REQ-002 SHALL provide parameter CNT_W, default 16, meaning the transfer-count width in bits (8..16).
REQ-003 SHALL provide parameter ADDR_W, default 16, meaning the DMA address width in bits.
REQ-004 Ports, one per line (CA_W = 3 + clog2(NCH)):
- CLK1  in  1  16x Phi2 clock; all logic on posedge.
- Reset  in  1  reset, synchronous, active-low.
- Phi2  in  1  system Phi2; sampled on CLK1.
- Halt  in  1  bus /HALT; 0 = DMA cycle granted.
- RegWr  in  1  one-CLK1 register write strobe.
- RegAddr  in  CA_W  register address {channel, offset[2:0]}.
- RegWData  in  8  write data.
- RegRData  out  8  combinational read data.
- DmaReqOut  out  1  bus request.
- DmaCycle  out  1  current Phi2 cycle is a DMA cycle.
- DmaAddr  out  ADDR_W  address of the current DMA cycle.
- DmaRead  out  1  1 = device-to-RAM, 0 = RAM-to-device.
- DmaDummy  out  1  current cycle is an alignment pad; no data moves.
- DmaChan  out  clog2(NCH) (min 1)  channel owning the current cycle.
- Irq  out  1  level interrupt.

Function
REQ-005 SHALL detect a cycle boundary when Phi2 is sampled 1 on one CLK1 edge and 0 on the next; all DMA state changes only at boundaries.
REQ-006 Per-channel offsets: 0 AddrLo, 1 AddrHi, 2 CountLo, 3 CountHi, 4 Control, 5 Status. Offsets 6-7 read 0 and ignore writes.
REQ-007 Count bits at or above CNT_W SHALL read 0 and be ignored on write.
REQ-008 Control register: bit0 Dir, bit1 Pad, bit2 IrqEn, bit6 Abort (write-only), bit7 Start (write-only).
REQ-009 Status register: bit0 Busy, bit1 Done (write 1 to clear), bit2 Aborted (write 1 to clear).
REQ-010 While Busy, writes to Addr, Count, Dir and Pad SHALL be ignored, and Start SHALL be ignored.
REQ-011 Start with Count=0 SHALL set Done immediately, leave Busy=0, and issue no cycles.
REQ-012 Start with Count≠0 SHALL set Busy and latch PadPending = Pad & Count[0].
REQ-013 A channel started in the same CLK1 as a boundary SHALL first be eligible at the following boundary.
REQ-014 DmaReqOut SHALL equal the OR of Busy over all channels.
REQ-015 At each boundary, if Halt=0 and any channel is Busy, a DMA cycle is granted for the next Phi2 cycle: DmaCycle=1, and the winner is chosen round-robin starting after the last-served channel; otherwise DmaCycle=0.
REQ-016 DmaAddr, DmaRead, DmaDummy and DmaChan SHALL be stable for the whole granted cycle.
REQ-017 At the end of a granted non-dummy cycle: Addr += 1 modulo 2^ADDR_W, and Count -= 1.
REQ-018 If Count becomes 0 and PadPending=1, the channel SHALL stay Busy for one dummy cycle: DmaDummy=1, same Addr, no decrement, PadPending cleared.
REQ-019 If Count becomes 0 and PadPending=0, or a dummy cycle ends, the channel SHALL set Busy=0 and Done=1.
REQ-020 Abort SHALL take effect at the next boundary: Busy=0, Aborted=1, Done unchanged; an in-progress granted cycle completes first.
REQ-021 Irq SHALL equal the OR over channels of (Done & IrqEn).
REQ-022 A Done set and a W1C of Done in the same CLK1 SHALL leave Done=1.

Reset
REQ-023 On Reset=0 at a CLK1 edge, all registers SHALL clear to 0: DmaReqOut=0, DmaCycle=0, DmaDummy=0, DmaChan=0, Irq=0, and the round-robin pointer=0.
REQ-024 A reset during a transfer SHALL abandon it without setting Done.
REQ-025 Boundary detection SHALL resume from the first Phi2 1->0 transition seen after reset release.

Verification
- Ch0: Addr=0x1000, Count=3, Dir=1, Start; Halt=0 -> 3 DMA cycles at 0x1000/1001/1002, then Done=1, Busy=0, DmaReqOut=0.
- Ch0: Count=3, Pad=1, IrqEn=1 -> 3 data cycles plus 1 dummy at 0x1003 (DmaDummy=1); Irq=1 after the dummy; Status W1C 0x02 -> Irq=0.
- Ch0 and ch1 each Count=2, started together -> DmaChan sequence 0,1,0,1.
- Addr=0xFFFF, Count=2 -> cycle addresses 0xFFFF then 0x0000.
- Halt=1 held for 4 boundaries mid-transfer -> no DmaCycle and Count frozen; resumes when Halt=0.
- Abort written after 1 of 5 cycles -> Aborted=1, Done=0, Count=4; Start with Count=0 -> Done=1 with no cycles.
